// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and byte-memory signals of the load/store unit
interface load_store_unit_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  busy;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  misalign;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  mem_read;
  logic                  mem_write;
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  busy, resp_valid, resp_rdata, misalign, mem_addr, mem_wdata, mem_read, mem_write
  );
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output busy, resp_valid, resp_rdata, misalign, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: splits MIPS loads/stores into one-byte-per-cycle memory accesses
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter bit BIG_ENDIAN = 1
) (
  input logic clk,
  input logic reset,
  load_store_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2;
  logic [1:0]            state, cnt, last, sz, nb1;
  logic                  wr, sgn, misalign_q, mem_read_q, mem_write_q, accept, bad;
  logic [31:0]           sreg, asm_q, asm_next, ext, rdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  assign bus.busy       = state == ACCESS;
  assign bus.resp_valid = state == DONE;
  assign bus.resp_rdata = rdata_q;
  assign bus.misalign   = misalign_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = BIG_ENDIAN ? sreg[31:24] : sreg[7:0];
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  // acceptance, alignment check, byte count and load assembly/extension
  always_comb begin
    accept   = bus.req_valid && (state == IDLE || state == DONE);
    bad      = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
               (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    nb1      = bus.req_size == 2'b00 ? 2'd0 : bus.req_size == 2'b01 ? 2'd1 : 2'd3;
    asm_next = BIG_ENDIAN ? {asm_q[23:0], bus.mem_rdata}
                          : asm_q | ({24'b0, bus.mem_rdata} << {cnt, 3'b000});
    ext      = sz == 2'b00 ? {{24{sgn & asm_next[7]}}, asm_next[7:0]} :
               sz == 2'b01 ? {{16{sgn & asm_next[15]}}, asm_next[15:0]} : asm_next;
  end
  // state machine; the store shift register presents the next byte on its top (BE) or bottom (LE)
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      last        <= 2'd0;
      sz          <= 2'd0;
      wr          <= 1'b0;
      sgn         <= 1'b0;
      sreg        <= 32'd0;
      asm_q       <= 32'd0;
      rdata_q     <= 32'd0;
      misalign_q  <= 1'b0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (accept) begin
      wr          <= bus.req_write;
      sgn         <= bus.req_signed;
      sz          <= bus.req_size;
      last        <= nb1;
      cnt         <= 2'd0;
      asm_q       <= 32'd0;
      rdata_q     <= 32'd0;
      misalign_q  <= bad;
      state       <= bad ? DONE : ACCESS;
      addr_q      <= bad ? addr_q : bus.req_addr;
      mem_read_q  <= !bad && !bus.req_write;
      mem_write_q <= !bad && bus.req_write;
      sreg        <= BIG_ENDIAN ? bus.req_wdata << {~nb1, 3'b000} : bus.req_wdata;
    end else if (state == ACCESS) begin
      asm_q <= asm_next;
      cnt   <= cnt + 2'd1;
      sreg  <= BIG_ENDIAN ? sreg << 8 : sreg >> 8;
      if (cnt == last) begin
        state       <= DONE;
        mem_read_q  <= 1'b0;
        mem_write_q <= 1'b0;
        misalign_q  <= 1'b0;
        rdata_q     <= wr ? 32'd0 : ext;
      end else begin
        addr_q <= addr_q + 1'b1;
      end
    end else if (state == DONE) begin
      state      <= IDLE;
      misalign_q <= 1'b0;
      rdata_q    <= 32'd0;
    end
  end
endmodule
